riscv_ifetch: RTL
=================

# riscv_ifetch

- Instruction fetch stage of the pipelined RISC-V core. It sits upstream of the IF/ID pipeline register.
- Issues word-aligned requests to instruction memory and tolerates variable memory latency.
- Buffers returned instructions, with their PCs, in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Taken branches redirect it through a redirect port, which discards everything in flight.

## Interface
Parameters:
- DEPTH, 4 — prefetch FIFO entries; power of two, at least 2. It also caps outstanding memory requests.
- RESET_PC, 32'h0000_0000 — first fetch address after reset.

Ports:
- clk  in  1  — rising-edge clock.
- rst_n  in  1  — reset; asynchronous assert, active-low.
- imem_req_valid  out  1  — fetch request valid.
- imem_req_ready  in  1  — memory accepts the request this cycle.
- imem_req_addr  out  32  — byte address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  — response valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  — instruction word.
- id_valid  out  1  — instruction available to decode.
- id_ready  in  1  — decode consumes the instruction this cycle.
- id_instr  out  32  — instruction word.
- id_pc  out  32  — PC of id_instr.
- redirect_valid  in  1  — branch/jump redirect, single-cycle pulse.
- redirect_pc  in  32  — new fetch PC; bits [1:0] are forced to 0 internally.

## Operation
- State:
  - fetch_pc: PC of the next request.
  - out_cnt: accepted requests not yet answered, 0..DEPTH.
  - drop_cnt: responses still to discard.
  - FIFO of {pc, instr} with occupancy count, 0..DEPTH.
- Counter width is $clog2(DEPTH)+1.
- FSM states:
  - RUN (reset state).
  - DRAIN: entered from RUN on a redirect when out_cnt minus same-cycle responses is greater than 0; returns to RUN when drop_cnt reaches 0.
  - A redirect while already in DRAIN stays in DRAIN and updates drop_cnt per the rule below.
- Request issue:
  - imem_req_valid = state==RUN && !redirect_valid && (count + out_cnt) < DEPTH.
  - On accept (valid && ready), fetch_pc += 4 (wraps modulo 2^32) and out_cnt increments.
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
- Response in RUN: {pc, data} is pushed. The response's pc is recorded in a PC FIFO at request time, or equivalently derived from the PC of the oldest outstanding request.
- Response in DRAIN: discarded; drop_cnt decrements.
- Every response decrements out_cnt.
- Decode output:
  - id_valid = FIFO non-empty && !redirect_valid.
  - A pop happens when id_valid && id_ready.
  - id_instr and id_pc show the FIFO head.
  - When the FIFO is empty, id_instr is NOP (32'h0000_0013) and id_pc holds its last value.
- Redirect in cycle n, effective at the edge ending cycle n:
  - FIFO cleared.
  - fetch_pc <= redirect_pc & ~3.
  - drop_cnt <= out_cnt − (imem_rsp_valid ? 1 : 0).
  - Any same-cycle response is dropped.
  - No request is issued and no pop occurs in cycle n.
- Simultaneous push and pop: count is unchanged; a push into a full FIFO cannot happen because of the issue credit rule.
- A response with out_cnt==0 is a protocol violation: it is ignored and flagged by a simulation assertion.
- Asynchronous reset mid-operation:
  - All counters and the FIFO clear, state returns to RUN, fetch_pc = RESET_PC.
  - Responses for pre-reset requests are the memory's responsibility to squash.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, id_valid 0, id_instr 32'h0000_0013, id_pc 0.
- First request: first clk edge cycle after rst_n deasserts.
- Memory latency L ≥ 1: id_valid rises L+1 cycles after acceptance (FIFO registered).
- Sustained throughput: 1 instruction/cycle when the memory is pipelined and DEPTH ≥ L+1.
- Redirect to first new request:
  - Next cycle if no request is outstanding.
  - Otherwise, the cycle after the final dropped response.

## Configuration
- IFETCH_BYPASS_EN defined:
  - A response arriving in RUN while the FIFO is empty is presented on id_* combinationally in the same cycle, so latency is L.
  - If id_ready is high, the response is not written to the FIFO.
- Undefined: every response is written to the FIFO first, giving latency L+1.

## Structure
- Shared package riscv_pkg holds:
  - NOP constant 32'h0000_0013.
  - Opcode localparams (LW, SW, BEQ, ALU-immediate).
  - XLEN = 32.
  - Fetch FSM state enum.
- One sub-module, ifetch_fifo: parameterised DEPTH × 64-bit synchronous FIFO with push/pop/clear, count, empty and full outputs, and an async active-low reset.

## Test plan
- Reset with RESET_PC=0x100, memory latency 1, id_ready=1 → requests to 0x100, 0x104, 0x108…; id_pc matches in order; one instruction per cycle after fill.
- id_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests accepted, imem_req_valid then 0; releasing id_ready drains 4 in order and issue resumes.
- Redirect to 0x203 with 3 requests outstanding at latency 3 → 3 responses dropped; DRAIN held until the last one; next request addr 0x200; no id_valid with stale PCs.
- Redirect in the same cycle as a response and a pop → response dropped, no pop, drop_cnt = out_cnt−1, FIFO empty next cycle.
- imem_req_ready toggling randomly → imem_req_addr is stable while stalled, and no duplicate or skipped PCs.
- Latency 1 with IFETCH_BYPASS_EN defined vs undefined → id_valid asserts in the response cycle vs one cycle later.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RISC-V core pipeline stages.
// Holds the data width, the canonical NOP, the major opcodes, the fetch
// FSM state type and a word-alignment helper.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0: what decode sees when nothing is available
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LW      = 7'b0000011;
    localparam logic [6:0] OPC_SW      = 7'b0100011;
    localparam logic [6:0] OPC_BEQ     = 7'b1100011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO used as the fetch prefetch
// buffer. Clear wins over push and pop in the same cycle. Push into a full
// FIFO and pop from an empty FIFO are ignored.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_clear,
    input  logic [WIDTH-1:0]        i_data,
    output logic [WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full  && !i_clear;
    assign w_do_pop  = i_pop  && !o_empty && !i_clear;

    // Storage write; entries are only ever read behind a valid count.
    // NOTE: the array has no reset -- occupancy is tracked by r_count, so
    // clearing the storage would only add reset fan-out for no behaviour.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the order of these statements cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/riscv_ifetch.sv
// riscv_ifetch: instruction fetch stage feeding the IF/ID register.
// Issues word-aligned requests, buffers {pc, instr} in a prefetch FIFO and
// hands them to decode over valid/ready. A redirect flushes the FIFO and
// discards every response still in flight (DRAIN state).
// Optional feature: define IFETCH_BYPASS_EN to present a response directly
// on id_* when the FIFO is empty, saving one cycle of fetch latency.
module riscv_ifetch
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_id_pc;
    logic [CW-1:0]     r_out_cnt;
    logic [CW-1:0]     r_drop_cnt;
    logic              r_active;

    logic              w_rsp;
    logic              w_rsp_live;
    logic              w_bypass;
    logic              w_show;
    logic              w_req_fire;
    logic              w_push;
    logic              w_pop;
    logic [CW:0]       w_credit;
    logic [CW-1:0]     w_rsp_remaining;
    logic [XLEN-1:0]   w_rsp_pc;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [63:0]       w_fifo_rdata;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp           = imem_rsp_valid && (r_out_cnt != '0);
    assign w_rsp_live      = w_rsp && (r_state == ST_RUN) && !redirect_valid;
    assign w_rsp_remaining = r_out_cnt - CW'(w_rsp);
    assign w_credit        = {1'b0, w_fifo_count} + {1'b0, r_out_cnt};
    // Outstanding requests in RUN are contiguous, so the oldest one's PC is
    // fetch_pc minus four bytes per outstanding request.
    assign w_rsp_pc        = r_fetch_pc - (XLEN'(r_out_cnt) << 2);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_rsp_live && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_show     = !w_fifo_empty || w_bypass;
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_pop      = id_valid && id_ready && !w_fifo_empty;
    // A bypassed response taken by decode this cycle never enters the FIFO.
    assign w_push     = w_rsp_live && !(w_bypass && id_ready);

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .i_data  ({w_rsp_pc, imem_rsp_data}),
        .o_data  (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: drain while stale responses remain after a redirect.
    // NOTE: the default assignment first makes every path drive w_state_nxt,
    // so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_rsp_remaining != '0) ? ST_DRAIN : ST_RUN;
        end else if (r_state == ST_DRAIN) begin
            if ((r_drop_cnt == '0) || ((r_drop_cnt == CW'(1)) && w_rsp)) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // FSM outputs: request issue under the credit rule and the decode view.
    always_comb begin
        imem_req_valid = r_active && (r_state == ST_RUN) && !redirect_valid
                         && (w_credit < CREDIT_MAX);
        imem_req_addr  = r_fetch_pc;
        id_valid       = w_show && !redirect_valid;
        if (!w_fifo_empty) begin
            id_instr = w_fifo_rdata[31:0];
            id_pc    = w_fifo_rdata[63:32];
        end else if (w_bypass) begin
            id_instr = imem_rsp_data;
            id_pc    = w_rsp_pc;
        end else begin
            id_instr = NOP;
            id_pc    = r_id_pc;
        end
    end

    // Fetch PC, in-flight counters and the held decode PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= word_align(RESET_PC);
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_id_pc    <= '0;
            r_active   <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_out_cnt <= r_out_cnt + CW'(w_req_fire) - CW'(w_rsp);
            if (redirect_valid) begin
                r_fetch_pc <= word_align(redirect_pc);
                r_drop_cnt <= w_rsp_remaining;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if ((r_state == ST_DRAIN) && w_rsp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
            if (w_show) r_id_pc <= id_pc;
        end
    end

    // Memory must not answer a request that was never accepted.
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_out_cnt != '0));

    // The issue credit must keep the FIFO from overflowing.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> !w_fifo_full);

endmodule
